// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared widths, ALU op codes and FSM states for the MEM stage
package mem_access_stage_pkg;

    localparam int REG_BUS_W      = 32;
    localparam int MEM_ADDR_BUS_W = 32;
    localparam int REG_ADDR_BUS_W = 5;
    localparam int ALU_OP_W       = 8;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t OP_ADD = 8'h20;
    localparam alu_op_t OP_LB  = 8'hE0;
    localparam alu_op_t OP_LH  = 8'hE1;
    localparam alu_op_t OP_LW  = 8'hE3;
    localparam alu_op_t OP_LBU = 8'hE4;
    localparam alu_op_t OP_LHU = 8'hE5;
    localparam alu_op_t OP_SB  = 8'hE8;
    localparam alu_op_t OP_SH  = 8'hE9;
    localparam alu_op_t OP_SW  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input alu_op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input alu_op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering: store enables/replication, load extract/extend
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int DW = 32
)
(
    input  alu_op_t       aluop,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] rdata,
    output logic [3:0]    be,
    output logic [DW-1:0] wdata,
    output logic [DW-1:0] load_data,
    output logic          misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lanes: byte n lives in rdata[8n+7:8n].
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be         = 4'b0000;
        wdata      = rt_data;
        load_data  = rdata;
        misaligned = 1'b0;
        case (aluop)
            OP_LB:  load_data = {{(DW-8){byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {{(DW-8){1'b0}}, byte_sel};
            OP_LH: begin
                load_data  = {{(DW-16){half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            OP_LHU: begin
                load_data  = {{(DW-16){1'b0}}, half_sel};
                misaligned = addr_lo[0];
            end
            OP_LW:  misaligned = |addr_lo;
            OP_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {(DW/8){rt_data[7:0]}};
            end
            OP_SH: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {(DW/16){rt_data[15:0]}};
                misaligned = addr_lo[0];
            end
            OP_SW: begin
                be         = 4'b1111;
                misaligned = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: bus access FSM, load capture, write-back steering
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned accesses trapped instead of forced aligned).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DW = REG_BUS_W,
    parameter int AW = MEM_ADDR_BUS_W
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_BUS_W-1:0] mem_reg_waddr,
    input  logic                      mem_we,
    input  logic [DW-1:0]             mem_reg_wdata,
    input  logic [AW-1:0]             mem_mem_addr,
    input  alu_op_t                   mem_aluop,
    input  logic [DW-1:0]             mem_rt_data,
    input  logic [5:0]                stall,
    input  logic [DW-1:0]             bus_rdata,
    input  logic                      bus_ack,
    output logic                      bus_req,
    output logic                      bus_we,
    output logic [AW-1:0]             bus_addr,
    output logic [3:0]                bus_be,
    output logic [DW-1:0]             bus_wdata,
    output logic                      stallreq_mem,
    output logic [REG_ADDR_BUS_W-1:0] wb_reg_waddr,
    output logic                      wb_we,
    output logic [DW-1:0]             wb_reg_wdata,
    output logic                      misalign
);

    mem_state_e    state, state_next;
    logic [DW-1:0] load_capture;
    logic [3:0]    lane_be;
    logic [DW-1:0] lane_wdata, lane_load;
    logic          lane_misaligned;
    logic          op_load, op_store, trap;
    logic          unused_stall;

    assign op_load      = is_load(mem_aluop);
    assign op_store     = is_store(mem_aluop);
    assign unused_stall = ^{stall[5], stall[3:0]};

    mem_lane_align #(.DW(DW)) u_lane_align (
        .aluop      (mem_aluop),
        .addr_lo    (mem_mem_addr[1:0]),
        .rt_data    (mem_rt_data),
        .rdata      (bus_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load),
        .misaligned (lane_misaligned)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (op_load || op_store) && lane_misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = lane_misaligned;
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            load_capture <= '0;
        end else begin
            state <= state_next;
            if (state == ST_REQ && bus_ack && op_load)
                load_capture <= lane_load;
        end
    end

    always_comb begin
        state_next   = state;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = '0;
        bus_be       = 4'b0000;
        bus_wdata    = '0;
        stallreq_mem = 1'b0;
        wb_reg_waddr = mem_reg_waddr;
        wb_we        = mem_we;
        wb_reg_wdata = mem_reg_wdata;
        misalign     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trap) begin
                    wb_we    = 1'b0;
                    misalign = 1'b1;
                end else if (op_load || op_store) begin
                    stallreq_mem = 1'b1;
                    wb_we        = 1'b0;
                    state_next   = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req      = 1'b1;
                bus_we       = op_store;
                bus_addr     = {mem_mem_addr[AW-1:2], 2'b00};
                bus_be       = lane_be;
                bus_wdata    = op_store ? lane_wdata : '0;
                stallreq_mem = 1'b1;
                wb_we        = 1'b0;
                if (bus_ack)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                // Held here while MEM is stalled so the access is never re-issued.
                if (op_store)
                    wb_we = 1'b0;
                if (op_load)
                    wb_reg_wdata = load_capture;
                if (!stall[4])
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (rst) begin
            bus_req      = 1'b0;
            bus_we       = 1'b0;
            bus_addr     = '0;
            bus_be       = 4'b0000;
            bus_wdata    = '0;
            stallreq_mem = 1'b0;
            wb_reg_waddr = '0;
            wb_we        = 1'b0;
            wb_reg_wdata = '0;
            misalign     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  mem_reg_waddr = '0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_reg_wdata = '0;
    logic [31:0] mem_mem_addr = '0;
    alu_op_t     mem_aluop = OP_ADD;
    logic [31:0] mem_rt_data = '0;
    logic [5:0]  stall = '0;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_req, bus_we, stallreq_mem, wb_we, misalign;
    logic [31:0] bus_addr, bus_wdata, wb_reg_wdata;
    logic [3:0]  bus_be;
    logic [4:0]  wb_reg_waddr;

    int checks = 0;
    int failures = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .mem_reg_waddr(mem_reg_waddr), .mem_we(mem_we), .mem_reg_wdata(mem_reg_wdata),
        .mem_mem_addr(mem_mem_addr), .mem_aluop(mem_aluop), .mem_rt_data(mem_rt_data),
        .stall(stall), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .stallreq_mem(stallreq_mem),
        .wb_reg_waddr(wb_reg_waddr), .wb_we(wb_we), .wb_reg_wdata(wb_reg_wdata),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic drive(input alu_op_t op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [4:0] waddr, input logic we, input logic [31:0] wdata);
        mem_aluop     = op;
        mem_mem_addr  = addr;
        mem_rt_data   = rt;
        mem_reg_waddr = waddr;
        mem_we        = we;
        mem_reg_wdata = wdata;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(OP_ADD, 32'h10, 32'h0, 5'd3, 1'b1, 32'h55);
        #1;
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_wb_we got=%b exp=0", wb_we); end
        checks++; if (wb_reg_wdata !== 32'h0) begin failures++; $display("FAIL reset_wb_wdata got=%h exp=0", wb_reg_wdata); end
        checks++; if (wb_reg_waddr !== 5'h0) begin failures++; $display("FAIL reset_wb_waddr got=%h exp=0", wb_reg_waddr); end
        checks++; if ({bus_req, stallreq_mem, misalign} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {bus_req, stallreq_mem, misalign}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        drive(OP_ADD, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
        bus_ack = 1'b1;
        #1;
        checks++; if (wb_reg_waddr !== 5'd5) begin failures++; $display("FAIL add_waddr got=%0d exp=5", wb_reg_waddr); end
        checks++; if (wb_we !== 1'b1) begin failures++; $display("FAIL add_we got=%b exp=1", wb_we); end
        checks++; if (wb_reg_wdata !== 32'h1234) begin failures++; $display("FAIL add_wdata got=%h exp=1234", wb_reg_wdata); end
        checks++; if (stallreq_mem !== 1'b0) begin failures++; $display("FAIL add_stallreq got=%b exp=0", stallreq_mem); end
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL add_bus_req got=%b exp=0", bus_req); end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++; if (stallreq_mem !== 1'b0) begin failures++; $display("FAIL stray_ack_stallreq got=%b exp=0", stallreq_mem); end
    endtask

    task automatic test_lb();
        int stall_cycles = 0;
        @(negedge clk);
        drive(OP_LB, 32'h103, 32'h0, 5'd7, 1'b1, 32'h103);
        #1;
        if (stallreq_mem === 1'b1) stall_cycles++;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL lb_idle_req got=%b exp=0", bus_req); end
        @(negedge clk);
        #1;
        if (stallreq_mem === 1'b1) stall_cycles++;
        checks++; if ({bus_req, bus_we} !== 2'b10) begin failures++; $display("FAIL lb_req_we got=%b exp=10", {bus_req, bus_we}); end
        checks++; if (bus_addr !== 32'h100) begin failures++; $display("FAIL lb_addr got=%h exp=100", bus_addr); end
        checks++; if (bus_be !== 4'b0000) begin failures++; $display("FAIL lb_be got=%b exp=0000", bus_be); end
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h80FF_FF00;
        #1;
        if (stallreq_mem === 1'b1) stall_cycles++;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'h1111_1111;
        #1;
        if (stallreq_mem === 1'b1) stall_cycles++;
        checks++; if (stall_cycles != 3) begin failures++; $display("FAIL lb_stall_cycles got=%0d exp=3", stall_cycles); end
        checks++; if (wb_reg_wdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", wb_reg_wdata); end
        checks++; if ({wb_we, bus_req} !== 2'b10) begin failures++; $display("FAIL lb_done_we_req got=%b exp=10", {wb_we, bus_req}); end
        checks++; if (wb_reg_waddr !== 5'd7) begin failures++; $display("FAIL lb_waddr got=%0d exp=7", wb_reg_waddr); end
    endtask

    task automatic test_sh();
        @(negedge clk);
        drive(OP_SH, 32'h102, 32'hAAAA_BEEF, 5'd9, 1'b1, 32'h102);
        #1;
        checks++; if (stallreq_mem !== 1'b1) begin failures++; $display("FAIL sh_idle_stall got=%b exp=1", stallreq_mem); end
        @(negedge clk);
        #1;
        checks++; if (bus_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", bus_be); end
        checks++; if (bus_wdata !== 32'hBEEF_BEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", bus_wdata); end
        checks++; if ({bus_req, bus_we} !== 2'b11) begin failures++; $display("FAIL sh_req_we got=%b exp=11", {bus_req, bus_we}); end
        checks++; if (bus_addr !== 32'h100) begin failures++; $display("FAIL sh_addr got=%h exp=100", bus_addr); end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++; if ({wb_we, stallreq_mem, bus_req} !== 3'b000) begin failures++; $display("FAIL sh_done got=%b exp=000", {wb_we, stallreq_mem, bus_req}); end
    endtask

    task automatic test_lhu();
        @(negedge clk);
        drive(OP_LHU, 32'h200, 32'h0, 5'd4, 1'b1, 32'h200);
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_8001;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        #1;
        checks++; if (wb_reg_wdata !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got=%h exp=00008001", wb_reg_wdata); end
        checks++; if ({wb_we, stallreq_mem} !== 2'b10) begin failures++; $display("FAIL lhu_done got=%b exp=10", {wb_we, stallreq_mem}); end
    endtask

    task automatic test_reset_in_req();
        @(negedge clk);
        drive(OP_LW, 32'h300, 32'h0, 5'd6, 1'b1, 32'h300);
        @(negedge clk);
        #1;
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rreq_before got=%b exp=1", bus_req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(OP_ADD, 32'h0, 32'h0, 5'd1, 1'b1, 32'h77);
        #1;
        checks++; if ({bus_req, stallreq_mem} !== 2'b00) begin failures++; $display("FAIL rreq_after got=%b exp=00", {bus_req, stallreq_mem}); end
        @(negedge clk);
        drive(OP_LW, 32'h304, 32'h0, 5'd6, 1'b1, 32'h304);
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++; if (wb_reg_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rreq_lw_data got=%h exp=deadbeef", wb_reg_wdata); end
        checks++; if (stallreq_mem !== 1'b0) begin failures++; $display("FAIL rreq_lw_stall got=%b exp=0", stallreq_mem); end
    endtask

    task automatic test_done_hold();
        @(negedge clk);
        drive(OP_LW, 32'h400, 32'h0, 5'd8, 1'b1, 32'h400);
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        stall     = 6'b010000;
        bus_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            #1;
            checks++; if ({bus_req, stallreq_mem} !== 2'b00) begin failures++; $display("FAIL hold_req_%0d got=%b exp=00", i, {bus_req, stallreq_mem}); end
            checks++; if (wb_reg_wdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL hold_data_%0d got=%h exp=0badf00d", i, wb_reg_wdata); end
        end
        stall = 6'b000000;
        @(negedge clk);
        drive(OP_ADD, 32'h0, 32'h0, 5'd2, 1'b1, 32'h99);
        #1;
        checks++; if ({bus_req, stallreq_mem} !== 2'b00) begin failures++; $display("FAIL hold_exit got=%b exp=00", {bus_req, stallreq_mem}); end
        checks++; if (wb_reg_wdata !== 32'h99) begin failures++; $display("FAIL hold_exit_data got=%h exp=99", wb_reg_wdata); end
    endtask

    task automatic test_misalign();
        @(negedge clk);
        drive(OP_LW, 32'h101, 32'h0, 5'd3, 1'b1, 32'h101);
        #1;
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if ({misalign, bus_req, stallreq_mem, wb_we} !== 4'b1000) begin failures++; $display("FAIL mis_trap got=%b exp=1000", {misalign, bus_req, stallreq_mem, wb_we}); end
        @(negedge clk);
        #1;
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL mis_trap_req got=%b exp=0", bus_req); end
        drive(OP_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
`else
        checks++; if ({misalign, stallreq_mem} !== 2'b01) begin failures++; $display("FAIL mis_off got=%b exp=01", {misalign, stallreq_mem}); end
        @(negedge clk);
        #1;
        checks++; if (bus_addr !== 32'h100) begin failures++; $display("FAIL mis_off_addr got=%h exp=100", bus_addr); end
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_0123;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        checks++; if (wb_reg_wdata !== 32'hCAFE_0123) begin failures++; $display("FAIL mis_off_data got=%h exp=cafe0123", wb_reg_wdata); end
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_lhu();
        test_reset_in_req();
        test_done_hold();
        test_misalign();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
